// File: rtl/alu_frame_sequencer.sv
// alu_frame_sequencer: pops A/B/opcode frames from the RX FIFO, runs the ALU,
// and pushes the result and status bytes into the TX FIFO.
module alu_frame_sequencer #(
    parameter int WORD_WIDTH     = 8,
    parameter int OPC_WIDTH      = 6,
    parameter int ALU_LATENCY    = 1,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_rxff_empty,
    input  logic [WORD_WIDTH-1:0] i_rxff_data,
    output logic                  o_rxff_read,
    input  logic                  i_txff_full,
    output logic                  o_txff_write,
    output logic [WORD_WIDTH-1:0] o_txff_data,
    output logic [WORD_WIDTH-1:0] o_operandA,
    output logic [WORD_WIDTH-1:0] o_operandB,
    output logic [OPC_WIDTH-1:0]  o_opcode,
    input  logic [WORD_WIDTH-1:0] i_result,
    input  logic                  i_alu_zero,
    input  logic                  i_alu_carry,
    output logic                  o_busy,
    output logic                  o_timeout
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int LW = ALU_LATENCY > 1 ? $clog2(ALU_LATENCY) : 1;

    typedef enum logic [2:0] {GET_A, GET_B, GET_OPC, EXEC, WR_RES, WR_STAT} state_t;

    state_t                state, state_n;
    logic [TW-1:0]         to_cnt;
    logic [LW-1:0]         lat_cnt;
    logic [WORD_WIDTH-1:0] result_q, status_q;
    logic                  waiting, pop, push, expire, lat_done, legal;
    logic                  unused_bits;

    assign unused_bits  = ^i_rxff_data[WORD_WIDTH-1:OPC_WIDTH];
    assign o_rxff_read  = pop;
    assign o_txff_write = push;
    assign o_txff_data  = state == WR_STAT ? status_q : result_q;
    assign o_busy       = state != GET_A;

    always_comb begin
        waiting  = state == GET_B || state == GET_OPC;
        pop      = (state == GET_A || waiting) && !i_rxff_empty && !i_reset;
        push     = (state == WR_RES || state == WR_STAT) && !i_txff_full && !i_reset;
        expire   = waiting && !pop && to_cnt == TW'(TIMEOUT_CYCLES - 1);
        lat_done = state == EXEC && lat_cnt == LW'(ALU_LATENCY - 1);
        legal    = o_opcode inside {OPC_WIDTH'(6'b100000), OPC_WIDTH'(6'b100010),
                                    OPC_WIDTH'(6'b100100), OPC_WIDTH'(6'b100101),
                                    OPC_WIDTH'(6'b100110), OPC_WIDTH'(6'b100111),
                                    OPC_WIDTH'(6'b000011), OPC_WIDTH'(6'b000010)};
        state_n  = state;
        case (state)
            GET_A:   state_n = pop ? GET_B : GET_A;
            GET_B:   state_n = pop ? GET_OPC : expire ? GET_A : GET_B;
            GET_OPC: state_n = pop ? EXEC : expire ? GET_A : GET_OPC;
            EXEC:    state_n = lat_done ? WR_RES : EXEC;
            WR_RES:  state_n = push ? WR_STAT : WR_RES;
            WR_STAT: state_n = push ? GET_A : WR_STAT;
            default: state_n = GET_A;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= GET_A;
            to_cnt     <= '0;
            lat_cnt    <= '0;
            o_operandA <= '0;
            o_operandB <= '0;
            o_opcode   <= '0;
            result_q   <= '0;
            status_q   <= '0;
            o_timeout  <= 1'b0;
        end else begin
            state     <= state_n;
            o_timeout <= expire;
            to_cnt    <= (pop || expire || !waiting) ? '0 : to_cnt + TW'(1);
            lat_cnt   <= (state == EXEC && !lat_done) ? lat_cnt + LW'(1) : '0;
            if (pop && state == GET_A) o_operandA <= i_rxff_data;
            if (pop && state == GET_B) o_operandB <= i_rxff_data;
            if (pop && state == GET_OPC) o_opcode <= i_rxff_data[OPC_WIDTH-1:0];
            // Illegal opcodes mask whatever the ALU happens to produce.
            if (lat_done) begin
                result_q <= legal ? i_result : '0;
                status_q <= WORD_WIDTH'({i_alu_carry & legal, i_alu_zero & legal, !legal});
            end
        end
    end
endmodule
